// File: rtl/decision_pkg.sv
// Shared fp16 constants, the fp16 score type and the NaN classifier used by the
// argmax decision stage.
package decision_pkg;

  localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
  localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

  typedef logic [15:0] fp16_t;

  function automatic logic is_nan(fp16_t x);
    return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_cmp.sv
// Combinational fp16 "a strictly greater than b" using a sign-folded unsigned key.
// Optional NaN filtering is selected by FP16_ARGMAX_NAN_FILTER_EN.
module fp16_cmp
  import decision_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output logic  a_gt_b
);

  fp16_t a_norm;
  fp16_t b_norm;
  logic [15:0] a_key;
  logic [15:0] b_key;
  logic key_gt;

  // -0 is folded onto +0 so the two zeros compare equal and never displace each other.
  always_comb begin
    a_norm = (a == FP16_NEG_ZERO) ? 16'h0000 : a;
    b_norm = (b == FP16_NEG_ZERO) ? 16'h0000 : b;
    a_key  = a_norm[15] ? ~a_norm : (a_norm | 16'h8000);
    b_key  = b_norm[15] ? ~b_norm : (b_norm | 16'h8000);
    key_gt = a_key > b_key;
  end

`ifdef FP16_ARGMAX_NAN_FILTER_EN
  always_comb begin
    if (is_nan(a)) begin
      a_gt_b = 1'b0;
    end else if (is_nan(b)) begin
      a_gt_b = 1'b1;
    end else begin
      a_gt_b = key_gt;
    end
  end
`else
  assign a_gt_b = key_gt;
`endif

endmodule

// File: rtl/fp16_argmax.sv
// Streaming argmax over NUM_CLASSES fp16 scores per frame; emits a one-cycle result pulse.
// Define FP16_ARGMAX_NAN_FILTER_EN to keep NaN scores from winning.
module fp16_argmax
  import decision_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           valid_in,
  input  logic [DATA_WIDTH-1:0]          score,
  output logic                           busy,
  output logic                           valid_out,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic [DATA_WIDTH-1:0]          max_score
);

  localparam int IDX_WIDTH = $clog2(NUM_CLASSES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic {COLLECT} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_WIDTH-1:0]  count_q, count_d;
  fp16_t                 run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic                  valid_out_q, valid_out_d;
  logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
  fp16_t                 max_score_q, max_score_d;

  logic  score_gt;
  logic  take;
  fp16_t new_max;
  logic [IDX_WIDTH-1:0] new_idx;

  fp16_cmp u_cmp (
    .a      (fp16_t'(score)),
    .b      (run_max_q),
    .a_gt_b (score_gt)
  );

  // The first score of a frame always loads; later ones need a strict win so ties keep the lower index.
  always_comb begin
    take    = (count_q == '0) || score_gt;
    new_max = take ? fp16_t'(score) : run_max_q;
    new_idx = take ? count_q : run_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    valid_out_d = 1'b0;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    case (state_q)
      COLLECT: begin
        if (flush) begin
          count_d = '0;
        end else if (valid_in) begin
          run_max_d = new_max;
          run_idx_d = new_idx;
          if (count_q == LAST_IDX) begin
            count_d     = '0;
            valid_out_d = 1'b1;
            class_idx_d = new_idx;
            max_score_d = new_max;
          end else begin
            count_d = count_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      valid_out_q <= 1'b0;
      class_idx_q <= '0;
      max_score_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      valid_out_q <= valid_out_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
    end
  end

  assign busy      = (count_q != '0);
  assign valid_out = valid_out_q;
  assign class_idx = class_idx_q;
  assign max_score = DATA_WIDTH'(max_score_q);

endmodule

// File: tb/tb_fp16_argmax.sv
// Directed self-checking bench for fp16_argmax with NUM_CLASSES=4: frame table plus
// hand-written back-to-back, flush and mid-frame reset sequences.
module tb_fp16_argmax;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [15:0] score;
  logic        busy;
  logic        valid_out;
  logic [1:0]  class_idx;
  logic [15:0] max_score;

  int nApplied = 0;
  int nMiss    = 0;

  typedef struct {
    string       name;
    logic [15:0] s [NC];
    logic [1:0]  idx;
    logic [15:0] mx;
  } vec_t;

  vec_t vecs [7];

  fp16_argmax #(.DATA_WIDTH(16), .NUM_CLASSES(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .score     (score),
    .busy      (busy),
    .valid_out (valid_out),
    .class_idx (class_idx),
    .max_score (max_score)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic applyStimulus(input logic v, input logic f, input logic [15:0] s);
    valid_in = v;
    flush    = f;
    score    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input vec_t v);
    for (int i = 0; i < NC; i++) begin
      applyStimulus(1'b1, 1'b0, v.s[i]);
      if (i < NC - 1) checkOutput({v.name, " early valid_out"}, 16'(valid_out), 16'h0);
    end
    valid_in = 1'b0;
    checkOutput({v.name, " valid_out"}, 16'(valid_out), 16'h1);
    checkOutput({v.name, " class_idx"}, 16'(class_idx), 16'(v.idx));
    checkOutput({v.name, " max_score"}, max_score, v.mx);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput({v.name, " pulse width"}, 16'(valid_out), 16'h0);
    checkOutput({v.name, " idx hold"}, 16'(class_idx), 16'(v.idx));
  endtask

  initial begin
    vecs[0] = '{"basic",     '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00}, 2'd1, 16'h4000};
    vecs[1] = '{"ties",      '{16'h4000, 16'h4000, 16'h3C00, 16'h4000}, 2'd0, 16'h4000};
    vecs[2] = '{"zeros",     '{16'h8000, 16'h0000, 16'hBC00, 16'h8000}, 2'd0, 16'h8000};
    vecs[3] = '{"subnormal", '{16'h0000, 16'h0001, 16'h8001, 16'h0000}, 2'd1, 16'h0001};
    vecs[4] = '{"neg inf",   '{16'hFC00, 16'hC000, 16'hFC00, 16'hC400}, 2'd1, 16'hC000};
    vecs[5] = '{"last wins", '{16'h3000, 16'h3400, 16'h3800, 16'h3C00}, 2'd3, 16'h3C00};
`ifdef FP16_ARGMAX_NAN_FILTER_EN
    vecs[6] = '{"nan",       '{16'h7E00, 16'h3C00, 16'h7C01, 16'h3800}, 2'd1, 16'h3C00};
`else
    vecs[6] = '{"nan",       '{16'h7E00, 16'h3C00, 16'h7C01, 16'h3800}, 2'd0, 16'h7E00};
`endif

    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; score = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy",      16'(busy),      16'h0);
    checkOutput("reset valid_out", 16'(valid_out), 16'h0);
    checkOutput("reset class_idx", 16'(class_idx), 16'h0);
    checkOutput("reset max_score", max_score,      16'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0);

    foreach (vecs[i]) runFrame(vecs[i]);

    // Back-to-back: eight beats with no bubble, pulses after beats 4 and 8.
    begin
      logic [15:0] bb [8];
      bb = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00};
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b1, 1'b0, bb[i]);
        checkOutput($sformatf("b2b valid_out beat %0d", i), 16'(valid_out),
                    (i == 3 || i == 7) ? 16'h1 : 16'h0);
        if (i == 3) begin
          checkOutput("b2b first idx", 16'(class_idx), 16'h0);
          checkOutput("b2b first max", max_score, 16'hBC00);
        end
        if (i == 7) begin
          checkOutput("b2b second idx", 16'(class_idx), 16'h3);
          checkOutput("b2b second max", max_score, 16'h7C00);
        end
      end
      applyStimulus(1'b0, 1'b0, 16'h0);
    end

    // Flush after two scores; the valid_in alongside flush is dropped.
    applyStimulus(1'b1, 1'b0, 16'h7C00);
    applyStimulus(1'b1, 1'b0, 16'h7800);
    checkOutput("pre-flush busy", 16'(busy), 16'h1);
    applyStimulus(1'b1, 1'b1, 16'h7BFF);
    checkOutput("flush busy", 16'(busy), 16'h0);
    checkOutput("flush valid_out", 16'(valid_out), 16'h0);
    runFrame('{"post flush", '{16'h3800, 16'h3C00, 16'h3400, 16'h3000}, 2'd1, 16'h3C00});

    // Asynchronous reset with count==2 clears immediately, without a clock edge.
    applyStimulus(1'b1, 1'b0, 16'h7C00);
    applyStimulus(1'b1, 1'b0, 16'h7C00);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy",      16'(busy),      16'h0);
    checkOutput("async rst valid_out", 16'(valid_out), 16'h0);
    checkOutput("async rst class_idx", 16'(class_idx), 16'h0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("after rst valid_out", 16'(valid_out), 16'h0);
    runFrame('{"after rst", '{16'hC000, 16'hB800, 16'hBC00, 16'hC400}, 2'd1, 16'hB800});

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
